alsu_pipe: RTL and testbench
============================

Name: alsu_pipe

Overview:
- Parametrised, handshaked successor to the fixed 3-bit ALSU datapath; used as both DUT-side RTL and scoreboard reference in the ALSU environment.
- Operand width, output pipeline depth and error-counter width are parameters.
- Adds an input valid qualifier, an output valid, an invalid-operation flag and a saturating error counter.
- The shift/rotate accumulator advances only on valid transactions.

Parameters:
- WIDTH, 3, signed operand width A/B (>=2).
- OUT_PIPE, 0, extra output register stages after the accumulator (0..4).
- ERR_W, 4, width of saturating invalid-operation counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  qualifies all operand/control inputs this cycle.
- A  in  WIDTH  signed operand A.
- B  in  WIDTH  signed operand B.
- opcode  in  3  0 OR, 1 XOR, 2 ADD, 3 MULT, 4 SHIFT, 5 ROTATE, 6/7 INVALID.
- cin  in  2  signed carry-in, ADD only.
- bypass_A, bypass_B  in  1  pass A (priority) or B sign-extended.
- red_op_A, red_op_B  in  1  reduction on A (priority) or B; legal with OR/XOR only.
- direction  in  1  1 = left, 0 = right for SHIFT/ROTATE.
- serial_in  in  1  bit shifted in on SHIFT.
- out  out  2*WIDTH  signed result.
- out_valid  out  1  out carries a new result.
- invalid  out  1  result is an invalid operation; aligned with out_valid.
- err_cnt  out  ERR_W  count of invalid operations, saturating.

Behaviour:
- Reset: synchronous, on rst high at a clk edge. All outputs are 0, including out, out_valid, invalid and err_cnt. The input register, accumulator and all pipe stages clear. Reset mid-operation discards every in-flight transaction, and out_valid is 0 in the following cycle.
- Stage 1, input register:
  - Captures all inputs and sets v1 = 1 when in_valid = 1.
  - Otherwise v1 = 0; captured data may hold.
- Stage 2, accumulator acc (OUT_W = 2*WIDTH):
  - Updates only when v1 = 1; otherwise it holds.
  - Priority order, evaluated on the stage-1 values:
    1. bypass_A: acc = sext(A).
    2. bypass_B: acc = sext(B).
    3. red_op_A or red_op_B with opcode not OR/XOR: acc = 0, inv = 1.
    4. opcode 6/7: acc = 0, inv = 1.
    5. OR: red_op_A gives {0, |A}; else red_op_B gives {0, |B}; else sext(A|B).
    6. XOR: same structure with ^.
    7. ADD: sext(A) + sext(B) + sext(cin), truncated to OUT_W, no saturation.
    8. MULT: full signed product A*B (fits OUT_W exactly).
    9. SHIFT: direction = 1 gives {acc[OUT_W-2:0], serial_in}; 0 gives {serial_in, acc[OUT_W-1:1]}.
    10. ROTATE: direction = 1 gives {acc[OUT_W-2:0], acc[OUT_W-1]}; 0 gives {acc[0], acc[OUT_W-1:1]}.
  - SHIFT/ROTATE use the accumulator value from the previous valid transaction, or 0 after reset.
  - inv = 0 for every case except 3 and 4.
- Output pipe:
  - {acc, v2, inv} is delayed by OUT_PIPE register stages, giving {out, out_valid, invalid}.
  - Latency from in_valid to out_valid is 2 + OUT_PIPE cycles.
  - Throughput is one transaction per cycle, with no backpressure.
- out holds its last value when out_valid = 0. invalid is 0 whenever out_valid = 0.
- err_cnt increments by 1 in the cycle out_valid & invalid is presented. It saturates at 2^ERR_W-1 and does not wrap.
- Back-to-back SHIFT/ROTATE: each valid beat acts on the result of the immediately preceding valid beat, even with idle cycles between them.

Test Plan:
- WIDTH=3, OUT_PIPE=0: reset, then A=3, B=-2, opcode ADD, cin=1, in_valid for 1 cycle -> 2 cycles later out=2 (6'b000010), out_valid=1 for 1 cycle, invalid=0.
- WIDTH=3: A=-4, B=-4, MULT -> out=16. Then A=3, B=-1, MULT -> out=-3 (6'b111101).
- WIDTH=3: bypass_A, A=-3 -> out=6'b111101. Next beat SHIFT, direction=1, serial_in=0 -> 6'b111010. Then 3 idle cycles, then ROTATE, direction=0 -> 6'b011101 (out holds between beats).
- WIDTH=3, ERR_W=2: five beats of red_op_A=1 with ADD -> each out=0, invalid=1. err_cnt goes 1, 2, 3, 3, 3. opcode 7 behaves the same.
- WIDTH=4, OUT_PIPE=2: A=5, B=-8, OR -> out=sext(4'b1101)=8'b11111101, 4 cycles after in_valid. Then red_op_B=1, XOR, B=4'b0111 -> out=1.
- Reset mid-flight: issue 3 valid beats and assert rst in the cycle after the 2nd -> out_valid stays 0 and err_cnt=0. The next SHIFT right, serial_in=1 -> out=100000 (WIDTH=3).

Source files
------------

// File: rtl/alsu_pipe.sv
// Parametrised, handshaked ALSU: input register, accumulator stage,
// optional output pipe and a saturating invalid-operation counter.
module alsu_pipe #(
    parameter int WIDTH    = 3,
    parameter int OUT_PIPE = 0,
    parameter int ERR_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic signed [WIDTH-1:0]   A,
    input  logic signed [WIDTH-1:0]   B,
    input  logic [2:0]                opcode,
    input  logic signed [1:0]         cin,
    input  logic                      bypass_A,
    input  logic                      bypass_B,
    input  logic                      red_op_A,
    input  logic                      red_op_B,
    input  logic                      direction,
    input  logic                      serial_in,
    output logic signed [2*WIDTH-1:0] out,
    output logic                      out_valid,
    output logic                      invalid,
    output logic [ERR_W-1:0]          err_cnt
);

    localparam int OUT_W = 2 * WIDTH;

    localparam logic [2:0] OP_OR   = 3'd0;
    localparam logic [2:0] OP_XOR  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_MULT = 3'd3;
    localparam logic [2:0] OP_SHFT = 3'd4;
    localparam logic [2:0] OP_ROT  = 3'd5;

    logic                    r_v1;
    logic signed [WIDTH-1:0] r_a;
    logic signed [WIDTH-1:0] r_b;
    logic [2:0]              r_op;
    logic signed [1:0]       r_cin;
    logic                    r_byp_a;
    logic                    r_byp_b;
    logic                    r_red_a;
    logic                    r_red_b;
    logic                    r_dir;
    logic                    r_sin;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_cin   <= '0;
            r_byp_a <= 1'b0;
            r_byp_b <= 1'b0;
            r_red_a <= 1'b0;
            r_red_b <= 1'b0;
            r_dir   <= 1'b0;
            r_sin   <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_a     <= A;
                r_b     <= B;
                r_op    <= opcode;
                r_cin   <= cin;
                r_byp_a <= bypass_A;
                r_byp_b <= bypass_B;
                r_red_a <= red_op_A;
                r_red_b <= red_op_B;
                r_dir   <= direction;
                r_sin   <= serial_in;
            end
        end
    end

    // Stage 0 of the pipe is the accumulator itself
    logic signed [OUT_W-1:0] r_acc [0:OUT_PIPE];
    logic                    r_v   [0:OUT_PIPE];
    logic                    r_inv [0:OUT_PIPE];

    logic signed [OUT_W-1:0] w_sa;
    logic signed [OUT_W-1:0] w_sb;
    logic signed [OUT_W-1:0] w_sc;
    logic signed [OUT_W-1:0] w_prod;
    logic signed [OUT_W-1:0] w_cur;
    logic signed [OUT_W-1:0] w_acc_nxt;
    logic                    w_inv;
    logic                    w_logic_op;

    assign w_sa       = {{WIDTH{r_a[WIDTH-1]}}, r_a};
    assign w_sb       = {{WIDTH{r_b[WIDTH-1]}}, r_b};
    assign w_sc       = {{(OUT_W-2){r_cin[1]}}, r_cin};
    assign w_prod     = w_sa * w_sb;
    assign w_cur      = r_acc[0];
    assign w_logic_op = (r_op == OP_OR) || (r_op == OP_XOR);

    always_comb begin
        w_acc_nxt = '0;
        w_inv     = 1'b0;
        if (r_byp_a) begin
            w_acc_nxt = w_sa;
        end else if (r_byp_b) begin
            w_acc_nxt = w_sb;
        end else if ((r_red_a || r_red_b) && !w_logic_op) begin
            w_inv = 1'b1;
        end else begin
            case (r_op)
                OP_OR: begin
                    if (r_red_a)
                        w_acc_nxt = {{(OUT_W-1){1'b0}}, |r_a};
                    else if (r_red_b)
                        w_acc_nxt = {{(OUT_W-1){1'b0}}, |r_b};
                    else
                        w_acc_nxt = w_sa | w_sb;
                end
                OP_XOR: begin
                    if (r_red_a)
                        w_acc_nxt = {{(OUT_W-1){1'b0}}, ^r_a};
                    else if (r_red_b)
                        w_acc_nxt = {{(OUT_W-1){1'b0}}, ^r_b};
                    else
                        w_acc_nxt = w_sa ^ w_sb;
                end
                OP_ADD:  w_acc_nxt = w_sa + w_sb + w_sc;
                OP_MULT: w_acc_nxt = w_prod;
                OP_SHFT: begin
                    if (r_dir)
                        w_acc_nxt = {w_cur[OUT_W-2:0], r_sin};
                    else
                        w_acc_nxt = {r_sin, w_cur[OUT_W-1:1]};
                end
                OP_ROT: begin
                    if (r_dir)
                        w_acc_nxt = {w_cur[OUT_W-2:0], w_cur[OUT_W-1]};
                    else
                        w_acc_nxt = {w_cur[0], w_cur[OUT_W-1:1]};
                end
                default: w_inv = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= OUT_PIPE; k++) begin
                r_acc[k] <= '0;
                r_v[k]   <= 1'b0;
                r_inv[k] <= 1'b0;
            end
        end else begin
            if (r_v1)
                r_acc[0] <= w_acc_nxt;
            r_v[0]   <= r_v1;
            r_inv[0] <= r_v1 & w_inv;
            for (int k = 1; k <= OUT_PIPE; k++) begin
                r_acc[k] <= r_acc[k-1];
                r_v[k]   <= r_v[k-1];
                r_inv[k] <= r_inv[k-1];
            end
        end
    end

    // Counter moves on the same edge the invalid result reaches the port
    logic w_err_inc;
    generate
        if (OUT_PIPE == 0) begin : g_err0
            assign w_err_inc = r_v1 & w_inv;
        end else begin : g_errn
            assign w_err_inc = r_v[OUT_PIPE-1] & r_inv[OUT_PIPE-1];
        end
    endgenerate

    logic [ERR_W-1:0] r_err;

    always_ff @(posedge clk) begin
        if (rst)
            r_err <= '0;
        else if (w_err_inc && (r_err != {ERR_W{1'b1}}))
            r_err <= r_err + 1'b1;
    end

    assign out       = r_acc[OUT_PIPE];
    assign out_valid = r_v[OUT_PIPE];
    assign invalid   = r_inv[OUT_PIPE];
    assign err_cnt   = r_err;

endmodule

// File: tb/tb_alsu_pipe.sv
// Directed bench for alsu_pipe: a WIDTH=3/OUT_PIPE=0/ERR_W=2 instance
// and a WIDTH=4/OUT_PIPE=2 instance.
module tb_alsu_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // instance a: WIDTH=3, OUT_PIPE=0, ERR_W=2
    logic              a_rst, a_iv;
    logic signed [2:0] a_A, a_B;
    logic [2:0]        a_op;
    logic signed [1:0] a_cin;
    logic              a_ba, a_bb, a_ra, a_rb, a_dir, a_sin;
    logic signed [5:0] a_out;
    logic              a_ov, a_inv;
    logic [1:0]        a_err;

    // instance b: WIDTH=4, OUT_PIPE=2, ERR_W=4
    logic              b_rst, b_iv;
    logic signed [3:0] b_A, b_B;
    logic [2:0]        b_op;
    logic signed [1:0] b_cin;
    logic              b_ba, b_bb, b_ra, b_rb, b_dir, b_sin;
    logic signed [7:0] b_out;
    logic              b_ov, b_inv;
    logic [3:0]        b_err;

    alsu_pipe #(.WIDTH(3), .OUT_PIPE(0), .ERR_W(2)) u_a (
        .clk(clk), .rst(a_rst), .in_valid(a_iv),
        .A(a_A), .B(a_B), .opcode(a_op), .cin(a_cin),
        .bypass_A(a_ba), .bypass_B(a_bb),
        .red_op_A(a_ra), .red_op_B(a_rb),
        .direction(a_dir), .serial_in(a_sin),
        .out(a_out), .out_valid(a_ov), .invalid(a_inv),
        .err_cnt(a_err)
    );

    alsu_pipe #(.WIDTH(4), .OUT_PIPE(2), .ERR_W(4)) u_b (
        .clk(clk), .rst(b_rst), .in_valid(b_iv),
        .A(b_A), .B(b_B), .opcode(b_op), .cin(b_cin),
        .bypass_A(b_ba), .bypass_B(b_bb),
        .red_op_A(b_ra), .red_op_B(b_rb),
        .direction(b_dir), .serial_in(b_sin),
        .out(b_out), .out_valid(b_ov), .invalid(b_inv),
        .err_cnt(b_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [2:0] op,
                           input logic [2:0] av, input logic [2:0] bv,
                           input logic [1:0] c,
                           input logic ba, input logic bb,
                           input logic ra, input logic rb,
                           input logic d, input logic s);
        a_iv = 1'b1; a_op = op; a_A = av; a_B = bv; a_cin = c;
        a_ba = ba; a_bb = bb; a_ra = ra; a_rb = rb;
        a_dir = d; a_sin = s;
    endtask

    task automatic drive_b(input logic [2:0] op,
                           input logic [3:0] av, input logic [3:0] bv,
                           input logic rb);
        b_iv = 1'b1; b_op = op; b_A = av; b_B = bv; b_cin = 2'b00;
        b_ba = 1'b0; b_bb = 1'b0; b_ra = 1'b0; b_rb = rb;
        b_dir = 1'b0; b_sin = 1'b0;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1;
        a_iv = 1'b0; b_iv = 1'b0;
        step(); step();
        checks++;
        if (a_out !== 6'd0 || a_ov !== 1'b0 || a_inv !== 1'b0 || a_err !== 2'd0) begin
            errors++;
            $display("FAIL reset_a: got out=%b ov=%b inv=%b err=%0d expected all 0",
                     a_out, a_ov, a_inv, a_err);
        end
        checks++;
        if (b_out !== 8'd0 || b_ov !== 1'b0 || b_inv !== 1'b0 || b_err !== 4'd0) begin
            errors++;
            $display("FAIL reset_b: got out=%b ov=%b inv=%b err=%0d expected all 0",
                     b_out, b_ov, b_inv, b_err);
        end
        a_rst = 1'b0; b_rst = 1'b0;
        step();
    endtask

    task automatic test_add();
        drive_a(3'd2, 3'b011, 3'b110, 2'b01, 0, 0, 0, 0, 0, 0);
        step();
        a_iv = 1'b0;
        checks++;
        if (a_ov !== 1'b0) begin
            errors++;
            $display("FAIL add_latency1: got ov=%b expected 0", a_ov);
        end
        step();
        checks++;
        if (a_out !== 6'b000010 || a_ov !== 1'b1 || a_inv !== 1'b0) begin
            errors++;
            $display("FAIL add_result: got out=%b ov=%b inv=%b expected 000010 1 0",
                     a_out, a_ov, a_inv);
        end
        step();
        checks++;
        if (a_ov !== 1'b0 || a_out !== 6'b000010) begin
            errors++;
            $display("FAIL add_pulse_hold: got out=%b ov=%b expected 000010 0",
                     a_out, a_ov);
        end
    endtask

    task automatic test_mult();
        drive_a(3'd3, 3'b100, 3'b100, 2'b00, 0, 0, 0, 0, 0, 0);
        step();
        drive_a(3'd3, 3'b011, 3'b111, 2'b00, 0, 0, 0, 0, 0, 0);
        step();
        a_iv = 1'b0;
        checks++;
        if (a_out !== 6'b010000 || a_ov !== 1'b1) begin
            errors++;
            $display("FAIL mult_neg_neg: got out=%b ov=%b expected 010000 1",
                     a_out, a_ov);
        end
        step();
        checks++;
        if (a_out !== 6'b111101 || a_ov !== 1'b1) begin
            errors++;
            $display("FAIL mult_pos_neg: got out=%b ov=%b expected 111101 1",
                     a_out, a_ov);
        end
        step();
    endtask

    task automatic test_shift_rotate();
        drive_a(3'd0, 3'b101, 3'b000, 2'b00, 1, 0, 0, 0, 0, 0);
        step();
        drive_a(3'd4, 3'b000, 3'b000, 2'b00, 0, 0, 0, 0, 1, 0);
        step();
        a_iv = 1'b0;
        checks++;
        if (a_out !== 6'b111101) begin
            errors++;
            $display("FAIL bypass_a: got out=%b expected 111101", a_out);
        end
        step();
        checks++;
        if (a_out !== 6'b111010 || a_ov !== 1'b1) begin
            errors++;
            $display("FAIL shift_left: got out=%b ov=%b expected 111010 1",
                     a_out, a_ov);
        end
        step(); step();
        checks++;
        if (a_out !== 6'b111010 || a_ov !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got out=%b ov=%b expected 111010 0",
                     a_out, a_ov);
        end
        drive_a(3'd5, 3'b000, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0);
        step();
        a_iv = 1'b0;
        step();
        checks++;
        if (a_out !== 6'b011101 || a_ov !== 1'b1) begin
            errors++;
            $display("FAIL rotate_right: got out=%b ov=%b expected 011101 1",
                     a_out, a_ov);
        end
        step();
    endtask

    task automatic test_errors();
        logic [1:0] exp_err;
        for (int i = 0; i < 5; i++) begin
            drive_a(3'd2, 3'b011, 3'b001, 2'b00, 0, 0, 1, 0, 0, 0);
            step();
            a_iv = 1'b0;
            step();
            exp_err = (i >= 2) ? 2'd3 : 2'(i + 1);
            checks++;
            if (a_out !== 6'd0 || a_ov !== 1'b1 || a_inv !== 1'b1 || a_err !== exp_err) begin
                errors++;
                $display("FAIL red_add_%0d: got out=%b ov=%b inv=%b err=%0d expected 0 1 1 %0d",
                         i, a_out, a_ov, a_inv, a_err, exp_err);
            end
        end
        drive_a(3'd0, 3'b111, 3'b000, 2'b00, 1, 0, 0, 0, 0, 0);
        step();
        drive_a(3'd7, 3'b011, 3'b011, 2'b00, 0, 0, 0, 0, 0, 0);
        step();
        a_iv = 1'b0;
        checks++;
        if (a_out !== 6'b111111 || a_inv !== 1'b0 || a_err !== 2'd3) begin
            errors++;
            $display("FAIL valid_between: got out=%b inv=%b err=%0d expected 111111 0 3",
                     a_out, a_inv, a_err);
        end
        step();
        checks++;
        if (a_out !== 6'd0 || a_inv !== 1'b1 || a_ov !== 1'b1 || a_err !== 2'd3) begin
            errors++;
            $display("FAIL opcode7: got out=%b ov=%b inv=%b err=%0d expected 0 1 1 3",
                     a_out, a_ov, a_inv, a_err);
        end
        step();
        checks++;
        if (a_inv !== 1'b0 || a_ov !== 1'b0) begin
            errors++;
            $display("FAIL inv_idle: got inv=%b ov=%b expected 0 0", a_inv, a_ov);
        end
    endtask

    task automatic test_pipe();
        drive_b(3'd0, 4'b0101, 4'b1000, 1'b0);
        step();
        b_iv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (b_ov !== 1'b0) begin
                errors++;
                $display("FAIL pipe_early_%0d: got ov=%b expected 0", i, b_ov);
            end
            step();
        end
        checks++;
        if (b_out !== 8'b11111101 || b_ov !== 1'b1 || b_inv !== 1'b0) begin
            errors++;
            $display("FAIL pipe_or: got out=%b ov=%b inv=%b expected 11111101 1 0",
                     b_out, b_ov, b_inv);
        end
        drive_b(3'd1, 4'b0000, 4'b0111, 1'b1);
        step();
        b_iv = 1'b0;
        step(); step(); step();
        checks++;
        if (b_out !== 8'd1 || b_ov !== 1'b1) begin
            errors++;
            $display("FAIL pipe_red_xor: got out=%b ov=%b expected 00000001 1",
                     b_out, b_ov);
        end
    endtask

    task automatic test_reset_midflight();
        drive_a(3'd0, 3'b111, 3'b000, 2'b00, 1, 0, 0, 0, 0, 0);
        step();
        drive_a(3'd2, 3'b001, 3'b001, 2'b00, 0, 0, 1, 0, 0, 0);
        step();
        drive_a(3'd7, 3'b001, 3'b001, 2'b00, 0, 0, 0, 0, 0, 0);
        a_rst = 1'b1;
        step();
        a_rst = 1'b0;
        a_iv = 1'b0;
        checks++;
        if (a_ov !== 1'b0 || a_err !== 2'd0 || a_out !== 6'd0 || a_inv !== 1'b0) begin
            errors++;
            $display("FAIL midflight_rst: got out=%b ov=%b inv=%b err=%0d expected all 0",
                     a_out, a_ov, a_inv, a_err);
        end
        step();
        checks++;
        if (a_ov !== 1'b0 || a_err !== 2'd0) begin
            errors++;
            $display("FAIL midflight_drain: got ov=%b err=%0d expected 0 0", a_ov, a_err);
        end
        drive_a(3'd4, 3'b000, 3'b000, 2'b00, 0, 0, 0, 0, 0, 1);
        step();
        a_iv = 1'b0;
        step();
        checks++;
        if (a_out !== 6'b100000 || a_ov !== 1'b1) begin
            errors++;
            $display("FAIL shift_after_rst: got out=%b ov=%b expected 100000 1",
                     a_out, a_ov);
        end
    endtask

    initial begin
        a_rst = 1'b1; a_iv = 1'b0; a_A = '0; a_B = '0; a_op = '0; a_cin = '0;
        a_ba = 0; a_bb = 0; a_ra = 0; a_rb = 0; a_dir = 0; a_sin = 0;
        b_rst = 1'b1; b_iv = 1'b0; b_A = '0; b_B = '0; b_op = '0; b_cin = '0;
        b_ba = 0; b_bb = 0; b_ra = 0; b_rb = 0; b_dir = 0; b_sin = 0;
        test_reset();
        test_add();
        test_mult();
        test_shift_rotate();
        test_errors();
        test_pipe();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
